// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data accesses.
// Define MEM_ARB_TIMEOUT_EN to build the BUSY watchdog and the sticky MemErr flag.
module mem_port_arbiter #(
    parameter int STARVE_MAX  = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IReqF,
    input  logic [31:0] IAddrF,
    input  logic        DReqM,
    input  logic        DWeM,
    input  logic [31:0] DAddrM,
    input  logic [31:0] DWdataM,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWdata,
    input  logic        MemAck,
    input  logic [31:0] MemRdata,
    output logic [31:0] InstrF,
    output logic        InstrValidF,
    output logic [31:0] ReadDataM,
    output logic        DataValidM,
    output logic        MemStallF,
    output logic        MemStallM,
    output logic        MemErr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;

    logic        busy;
    logic        timeout;
    logic        done;
    logic        fetch_wins;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
`endif

    assign busy = (state_q != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    // Abort in the TIMEOUT_CYC-th BUSY cycle if the memory still has not acknowledged.
    assign timeout = busy && !MemAck && (tcnt_q == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    assign done       = busy && (MemAck || timeout);
    assign fetch_wins = IReqF && (starve_q >= 4'(STARVE_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        tcnt_d = '0;
        if (busy && !done) begin
            tcnt_d = tcnt_q + 1'b1;
        end
        err_d = err_q | timeout;
    end

    assign MemErr = err_q;
`else
    assign MemErr = 1'b0;
`endif

    // Next-state logic: arbitration in IDLE, completion in BUSY.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        case (state_q)
            IDLE: begin
                if (DReqM && !fetch_wins) begin
                    state_d = DBUSY;
                    addr_d  = DAddrM;
                    wdata_d = DWdataM;
                    we_d    = DWeM;
                    if (IReqF) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (IReqF) begin
                    state_d  = IBUSY;
                    addr_d   = IAddrF;
                    wdata_d  = 32'd0;
                    we_d     = 1'b0;
                    starve_d = 4'd0;
                end
            end
            IBUSY, DBUSY: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        MemReq      = 1'b0;
        MemWe       = 1'b0;
        MemAddr     = 32'd0;
        MemWdata    = 32'd0;
        InstrF      = 32'd0;
        InstrValidF = 1'b0;
        ReadDataM   = 32'd0;
        DataValidM  = 1'b0;
        case (state_q)
            IBUSY: begin
                MemReq      = 1'b1;
                MemAddr     = addr_q;
                MemWdata    = wdata_q;
                InstrValidF = done;
                if (MemAck) begin
                    InstrF = MemRdata;
                end
            end
            DBUSY: begin
                MemReq     = 1'b1;
                MemWe      = we_q;
                MemAddr    = addr_q;
                MemWdata   = wdata_q;
                DataValidM = done;
                // Stores and aborted accesses return zero data.
                if (MemAck && !we_q) begin
                    ReadDataM = MemRdata;
                end
            end
            default: begin
            end
        endcase
    end

    assign MemStallF = IReqF & ~InstrValidF;
    assign MemStallM = DReqM & ~DataValidM;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single accesses plus hand-written conflict,
// starvation, reset and (with MEM_ARB_TIMEOUT_EN) watchdog sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        IReqF = 1'b0;
    logic [31:0] IAddrF = 32'd0;
    logic        DReqM = 1'b0;
    logic        DWeM = 1'b0;
    logic [31:0] DAddrM = 32'd0;
    logic [31:0] DWdataM = 32'd0;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWdata;
    logic        MemAck = 1'b0;
    logic [31:0] MemRdata = 32'd0;
    logic [31:0] InstrF, ReadDataM;
    logic        InstrValidF, DataValidM, MemStallF, MemStallM, MemErr;

    mem_port_arbiter #(.STARVE_MAX(3), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset),
        .IReqF(IReqF), .IAddrF(IAddrF),
        .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemAck(MemAck), .MemRdata(MemRdata),
        .InstrF(InstrF), .InstrValidF(InstrValidF),
        .ReadDataM(ReadDataM), .DataValidM(DataValidM),
        .MemStallF(MemStallF), .MemStallM(MemStallM), .MemErr(MemErr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } sb_t;

    sb_t sb_q[$];
    logic sb_en = 1'b1;

    // Output monitor: every valid pulse must match the oldest pending expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb_en) begin
                if (!InstrValidF) chk("InstrF_zero", InstrF, 32'd0);
                if (!DataValidM)  chk("ReadDataM_zero", ReadDataM, 32'd0);
                if (InstrValidF && DataValidM) begin
                    chk("dual_pulse", 32'd1, 32'd0);
                end else if (InstrValidF || DataValidM) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_pulse", {31'd0, DataValidM}, {31'd0, InstrValidF});
                        chk("unexpected_pulse_any", 32'd1, 32'd0);
                    end else begin
                        sb_t e;
                        e = sb_q.pop_front();
                        chk("sb_kind", {31'd0, DataValidM}, {31'd0, e.is_d});
                        chk("sb_data", DataValidM ? ReadDataM : InstrF, e.data);
                    end
                end
            end
        end
    end

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[6];

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        IReqF = 1'b0; DReqM = 1'b0; DWeM = 1'b0; MemAck = 1'b0;
        #1;
        chk("rst_MemReq", {31'd0, MemReq}, 32'd0);
        chk("rst_MemWe", {31'd0, MemWe}, 32'd0);
        chk("rst_MemAddr", MemAddr, 32'd0);
        chk("rst_MemErr", {31'd0, MemErr}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic gr[16];
        logic exp_gr[8];
        int   g;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'hE3A0_1005, 0, 32'hE3A0_1005};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'hCAFE_F00D, 3, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         32'h1234_5678, 1, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         32'hE59F_1004, 2, 32'hE59F_1004};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFF, 0, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'h7777_7777, 0, 32'h0};
        exp_gr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        #1;
        chk("init_MemReq", {31'd0, MemReq}, 32'd0);
        chk("init_valid", {30'd0, InstrValidF, DataValidM}, 32'd0);
        reset = 1'b1;

        // Single accesses from the table.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            IReqF = !vecs[v].is_d; IAddrF = vecs[v].addr;
            DReqM = vecs[v].is_d;  DAddrM = vecs[v].addr;
            DWeM = vecs[v].we;     DWdataM = vecs[v].wdata;
            MemAck = 1'b0; MemRdata = 32'hA5A5_A5A5;
            sb_q.push_back('{vecs[v].is_d, vecs[v].exp_out});
            #1;
            chk("idle_MemReq", {31'd0, MemReq}, 32'd0);
            chk("idle_stall", {30'd0, MemStallF, MemStallM}, vecs[v].is_d ? 32'd1 : 32'd2);
            for (int k = 0; k <= vecs[v].waits; k++) begin
                @(negedge clk);
                IAddrF = ~vecs[v].addr; DAddrM = ~vecs[v].addr; DWdataM = 32'h0BAD_0BAD;
                MemAck = (k == vecs[v].waits);
                MemRdata = (k == vecs[v].waits) ? vecs[v].rdata : 32'h5A5A_5A5A;
                #1;
                chk("busy_MemReq", {31'd0, MemReq}, 32'd1);
                chk("busy_MemAddr", MemAddr, vecs[v].addr);
                chk("busy_MemWe", {31'd0, MemWe}, {31'd0, vecs[v].is_d & vecs[v].we});
                if (vecs[v].is_d) begin
                    chk("busy_MemWdata", MemWdata, vecs[v].wdata);
                    chk("busy_DValid", {31'd0, DataValidM}, {31'd0, k == vecs[v].waits});
                    chk("busy_StallM", {31'd0, MemStallM}, {31'd0, k != vecs[v].waits});
                end else begin
                    chk("busy_IValid", {31'd0, InstrValidF}, {31'd0, k == vecs[v].waits});
                    chk("busy_StallF", {31'd0, MemStallF}, {31'd0, k != vecs[v].waits});
                end
            end
            @(negedge clk);
            IReqF = 1'b0; DReqM = 1'b0; MemAck = 1'b0;
            #1;
            chk("post_MemReq", {31'd0, MemReq}, 32'd0);
        end

        // Load/fetch conflict below the starvation limit: data first, then fetch.
        do_reset();
        @(negedge clk);
        IReqF = 1'b1; IAddrF = 32'h400;
        DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h300;
        sb_q.push_back('{1'b1, 32'h1234_5678});
        sb_q.push_back('{1'b0, 32'hE3A0_1005});
        #1;
        chk("cf_stalls", {30'd0, MemStallF, MemStallM}, 32'd3);
        @(negedge clk);
        MemAck = 1'b1; MemRdata = 32'h1234_5678;
        #1;
        chk("cf_d_addr", MemAddr, 32'h300);
        chk("cf_d_rdata", ReadDataM, 32'h1234_5678);
        chk("cf_d_valids", {30'd0, InstrValidF, DataValidM}, 32'd1);
        chk("cf_d_stallF", {31'd0, MemStallF}, 32'd1);
        @(negedge clk);
        DReqM = 1'b0; MemAck = 1'b0;
        #1;
        chk("cf_idle", {31'd0, MemReq}, 32'd0);
        @(negedge clk);
        MemAck = 1'b1; MemRdata = 32'hE3A0_1005;
        #1;
        chk("cf_i_addr", MemAddr, 32'h400);
        chk("cf_i_instr", InstrF, 32'hE3A0_1005);
        chk("cf_i_stallF", {31'd0, MemStallF}, 32'd0);
        @(negedge clk);
        IReqF = 1'b0; MemAck = 1'b0;

        // Starvation: both requests held, zero-wait memory.
        do_reset();
        @(negedge clk);
        sb_en = 1'b0;
        IReqF = 1'b1; IAddrF = 32'h1000;
        DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h2000;
        MemAck = 1'b1; MemRdata = 32'h0;
        g = 0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (MemReq && g < 16) begin
                gr[g] = (MemAddr == 32'h2000);
                g++;
            end
        end
        chk("starve_grants", g, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("starve_grant%0d", i), {31'd0, gr[i]}, {31'd0, exp_gr[i]});
        end
        @(negedge clk);
        IReqF = 1'b0; DReqM = 1'b0; MemAck = 1'b0;
        @(negedge clk);
        sb_en = 1'b1;

        // Reset during a store: request drops at once and no pulse follows.
        do_reset();
        @(negedge clk);
        DReqM = 1'b1; DWeM = 1'b1; DAddrM = 32'h80; DWdataM = 32'h11;
        @(negedge clk);
        DReqM = 1'b0;
        #1;
        chk("mid_MemReq", {31'd0, MemReq}, 32'd1);
        chk("mid_MemWe", {31'd0, MemWe}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_MemReq", {31'd0, MemReq}, 32'd0);
        chk("mid_rst_MemWe", {31'd0, MemWe}, 32'd0);
        @(negedge clk);
        reset = 1'b1; MemAck = 1'b1; MemRdata = 32'h9999_9999;
        #1;
        chk("mid_after_MemReq", {31'd0, MemReq}, 32'd0);
        chk("mid_after_DValid", {31'd0, DataValidM}, 32'd0);
        @(negedge clk);
        MemAck = 1'b0;
        #1;
        chk("spurious_ack_idle", {31'd0, MemReq}, 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        @(negedge clk);
        IReqF = 1'b1; IAddrF = 32'h500; MemAck = 1'b0;
        sb_q.push_back('{1'b0, 32'h0});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            chk("to_MemReq", {31'd0, MemReq}, 32'd1);
            chk("to_IValid", {31'd0, InstrValidF}, {31'd0, k == 8});
            chk("to_MemErr_pre", {31'd0, MemErr}, 32'd0);
        end
        @(negedge clk);
        IReqF = 1'b0;
        #1;
        chk("to_MemErr_set", {31'd0, MemErr}, 32'd1);
        chk("to_idle", {31'd0, MemReq}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("to_MemErr_sticky", {31'd0, MemErr}, 32'd1);
`else
        chk("MemErr_off", {31'd0, MemErr}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified instruction/data memory port between the Fetch stage (instruction reads) and the Memory stage (loads/stores).
- Sequences each access with a request/acknowledge handshake and tolerates variable memory latency.
- Arbitrates simultaneous requests, with data given priority plus anti-starvation for fetch.
- Produces per-stage memory stalls that the hazard unit ORs into StallF and the Memory-stage stall.

Parameters:
- STARVE_MAX, 3: consecutive fetch losses after which fetch wins the next conflict (1..15).
- TIMEOUT_CYC, 64: watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- IReqF  input  1  fetch read request
- IAddrF  input  32  fetch address
- DReqM  input  1  data request (load or store)
- DWeM  input  1  1 = store, 0 = load
- DAddrM  input  32  data address
- DWdataM  input  32  store data
- MemReq  output  1  memory request, held until MemAck
- MemWe  output  1  memory write enable
- MemAddr  output  32  memory address
- MemWdata  output  32  memory write data
- MemAck  input  1  memory completes the access this cycle
- MemRdata  input  32  memory read data, valid with MemAck
- InstrF  output  32  fetched instruction
- InstrValidF  output  1  one-cycle pulse: InstrF valid
- ReadDataM  output  32  load data
- DataValidM  output  1  one-cycle pulse: load or store complete
- MemStallF  output  1  fetch stall to hazard unit
- MemStallM  output  1  memory-stage stall to hazard unit
- MemErr  output  1  sticky timeout error; 0 when the optional feature is off

Behaviour:
- FSM states: IDLE, IBUSY, DBUSY.
- On reset assertion (asynchronous): state IDLE, starve counter 0, latched address/data/we registers 0, MemErr 0. MemReq, MemWe and both valid pulses drop immediately.
- Any access in flight when reset asserts is abandoned; no valid pulse is produced for it.
- IDLE arbitration, evaluated each cycle:
  - DReqM only: latch DAddrM/DWdataM/DWeM, go to DBUSY.
  - IReqF only: latch IAddrF, go to IBUSY.
  - Both, starve counter < STARVE_MAX: data wins; starve counter +1.
  - Both, starve counter == STARVE_MAX: fetch wins.
  - Whenever fetch is granted: starve counter cleared.
  - Neither: stay in IDLE.
- The starve counter saturates at STARVE_MAX and never wraps.
- IBUSY/DBUSY:
  - MemReq = 1; MemAddr/MemWe/MemWdata driven from the latched registers, stable until MemAck.
  - MemWe = 1 only in DBUSY with a latched store.
  - In IDLE: MemReq = 0, MemWe = 0, MemAddr and MemWdata = 0.
- Completion:
  - IBUSY and MemAck: InstrValidF = 1 and InstrF = MemRdata in the same cycle (combinational); next state IDLE.
  - DBUSY and MemAck: DataValidM = 1 in the same cycle; ReadDataM = MemRdata for loads, 0 for stores; next state IDLE.
  - When no valid pulse is asserted, InstrF and ReadDataM are 0.
- Latency:
  - Request seen in IDLE at cycle N → MemReq high from N+1.
  - Zero-wait memory (MemAck at N+1) → valid pulse at N+1.
  - Port throughput is one access per 2 cycles minimum.
- Stalls:
  - MemStallF = IReqF & ~InstrValidF.
  - MemStallM = DReqM & ~DataValidM.
  - Both are combinational.
- A request still asserted in the cycle after its valid pulse is treated as a new access.
- Request inputs are sampled only in IDLE; changes during BUSY are ignored.
- Spurious MemAck in IDLE is ignored: no pulse, no state change.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs during IBUSY/DBUSY and clears on entry to IDLE.
  - If the counter reaches TIMEOUT_CYC without MemAck: the access is aborted, the FSM returns to IDLE, the stalled requester gets a valid pulse with data 0, and MemErr is set.
  - MemErr stays set until reset.
- Undefined: no counter is built, MemErr is tied to 0, and BUSY states wait indefinitely.

Test Plan:
- Reset mid-access: reset low during DBUSY with MemReq = 1 → MemReq and MemWe go to 0 immediately; after release, state is IDLE and no DataValidM pulse occurs.
- Lone fetch, zero wait: IReqF = 1, IAddrF = 0x100, MemAck = 1 with MemRdata = 0xE3A01005 → MemAddr = 0x100 at N+1; InstrValidF = 1 with InstrF = 0xE3A01005 at N+1; MemStallF = 1 at N only.
- Store with 3 wait states: DReqM = 1, DWeM = 1, DAddrM = 0x40, DWdataM = 0xDEADBEEF → MemReq, MemWe, MemAddr and MemWdata held stable for 4 cycles; DataValidM pulses with MemAck; ReadDataM = 0; MemStallM high until then.
- Starvation: IReqF and DReqM held high, STARVE_MAX = 3, zero-wait memory → grant order D, D, D, I, D, D, D, I.
- Load/fetch conflict with STARVE_MAX not reached: data granted first; fetch is served in the next IDLE; ReadDataM = MemRdata = 0x12345678 on the load ack.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC = 8, MemAck never asserted on a fetch → abort after 8 BUSY cycles; InstrValidF pulses with InstrF = 0; MemErr = 1 and stays at 1.
